// File: rtl/alu_pkg.sv
// Shared encodings for the 8-bit byte ALU and its multi-byte sequencer.
package alu_pkg;

  localparam logic [3:0] OpAdd    = 4'd0;
  localparam logic [3:0] OpSub    = 4'd1;
  localparam logic [3:0] OpLshift = 4'd2;
  localparam logic [3:0] OpRshift = 4'd3;
  localparam logic [3:0] OpXor    = 4'd4;
  localparam logic [3:0] OpCmp    = 4'd5;
  localparam logic [3:0] OpAnd    = 4'd6;
  localparam logic [3:0] OpNand   = 4'd7;
  localparam logic [3:0] OpOr     = 4'd8;
  localparam logic [3:0] OpNor    = 4'd9;

  localparam logic [7:0] CmpEq = 8'h01;
  localparam logic [7:0] CmpGt = 8'h02;
  localparam logic [7:0] CmpLt = 8'h03;

  typedef enum logic [1:0] {StIdle, StRun, StDone} seq_state_e;

  function automatic logic is_valid_op(input logic [3:0] op);
    return op <= OpNor;
  endfunction

endpackage

// File: rtl/alu_mb_sequencer.sv
// Issues one multi-byte command to the external 8-bit ALU, one byte per cycle, chaining
// carry/shift bits between bytes and returning the assembled result.
module alu_mb_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned NBYTES = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [3:0]          cmd_opcode_i,
  input  logic [8*NBYTES-1:0] cmd_a_i,
  input  logic [8*NBYTES-1:0] cmd_b_i,
  input  logic                cmd_cin_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [8*NBYTES-1:0] rsp_q_o,
  output logic                rsp_cout_o,
  output logic                rsp_err_o,
  output logic                busy_o,
  output logic [7:0]          alu_op_a_o,
  output logic [7:0]          alu_op_b_o,
  output logic [3:0]          alu_opcode_o,
  output logic                alu_cin_o,
  input  logic [7:0]          alu_out_q_i,
  input  logic                alu_cout_i
);

  localparam int unsigned W  = 8 * NBYTES;
  localparam int unsigned KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [KW-1:0] KLast = KW'(NBYTES - 1);

  seq_state_e    state_q, state_d;
  logic [3:0]    op_q, op_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  res_q, res_d;
  logic [KW-1:0] k_q, k_d;
  logic [7:0]    cmp_q, cmp_d;
  logic          carry_q, carry_d;
  logic          cout_q, cout_d;
  logic          err_q, err_d;

  logic          descending;
  logic          chain_op;
  logic [KW-1:0] byte_idx;
  logic [7:0]    a_byte;
  logic [7:0]    b_byte;

  assign descending = (op_q == OpRshift) || (op_q == OpCmp);
  assign chain_op   = (op_q == OpAdd) || (op_q == OpSub) ||
                      (op_q == OpLshift) || (op_q == OpRshift);
  assign byte_idx   = descending ? (KLast - k_q) : k_q;
  assign a_byte     = a_q[8*byte_idx +: 8];
  assign b_byte     = b_q[8*byte_idx +: 8];

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    res_d        = res_q;
    k_d          = k_q;
    cmp_d        = cmp_q;
    carry_d      = carry_q;
    cout_d       = cout_q;
    err_d        = err_q;
    alu_op_a_o   = '0;
    alu_op_b_o   = '0;
    alu_opcode_o = '0;
    alu_cin_o    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          state_d = StRun;
          op_d    = cmd_opcode_i;
          a_d     = cmd_a_i;
          b_d     = cmd_b_i;
          k_d     = '0;
          res_d   = '0;
          cmp_d   = CmpEq;
          cout_d  = 1'b0;
          err_d   = !is_valid_op(cmd_opcode_i);
          // Subtraction is A + ~B + 1, so its chain always starts with carry 1.
          if (cmd_opcode_i == OpSub) begin
            carry_d = 1'b1;
          end else if ((cmd_opcode_i == OpAdd) || (cmd_opcode_i == OpLshift) ||
                       (cmd_opcode_i == OpRshift)) begin
            carry_d = cmd_cin_i;
          end else begin
            carry_d = 1'b0;
          end
        end
      end
      StRun: begin
        if (is_valid_op(op_q)) begin
          alu_op_a_o   = a_byte;
          alu_op_b_o   = (op_q == OpSub) ? ~b_byte : b_byte;
          alu_opcode_o = (op_q == OpSub) ? OpAdd : op_q;
          alu_cin_o    = chain_op ? carry_q : 1'b0;
          if (op_q == OpCmp) begin
            // The most significant differing byte decides; later bytes cannot override it.
            if ((cmp_q == CmpEq) && (alu_out_q_i != CmpEq)) begin
              cmp_d = alu_out_q_i;
            end
          end else begin
            res_d[8*byte_idx +: 8] = alu_out_q_i;
          end
          if ((op_q == OpAdd) || (op_q == OpSub)) begin
            carry_d = alu_cout_i;
          end else if (op_q == OpLshift) begin
            carry_d = a_byte[7];
          end else if (op_q == OpRshift) begin
            carry_d = b_byte[0];
          end
        end
        k_d = k_q + 1'b1;
        if (k_q == KLast) begin
          state_d = StDone;
          cout_d  = chain_op ? carry_d : 1'b0;
          if (op_q == OpCmp) begin
            res_d = W'(cmp_d);
          end
        end
      end
      StDone: begin
        if (rsp_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      k_q     <= '0;
      cmp_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      k_q     <= k_d;
      cmp_q   <= cmp_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready_o = (state_q == StIdle);
  assign rsp_valid_o = (state_q == StDone);
  assign busy_o      = (state_q != StIdle);
  assign rsp_q_o     = res_q;
  assign rsp_cout_o  = cout_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_alu_mb_sequencer.sv
// Bench for alu_mb_sequencer with a behavioural 8-bit ALU attached and a full-width
// reference model of each multi-byte command.
module tb_alu_mb_sequencer;

  localparam int unsigned NB = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_opcode;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic        cmd_cin;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_q;
  logic        rsp_cout;
  logic        rsp_err;
  logic        busy;
  logic [7:0]  alu_op_a;
  logic [7:0]  alu_op_b;
  logic [3:0]  alu_opcode;
  logic        alu_cin;
  logic [7:0]  alu_out_q;
  logic        alu_cout;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_mb_sequencer #(.NBYTES(NB)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_opcode_i(cmd_opcode),
    .cmd_a_i     (cmd_a),
    .cmd_b_i     (cmd_b),
    .cmd_cin_i   (cmd_cin),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_q_o     (rsp_q),
    .rsp_cout_o  (rsp_cout),
    .rsp_err_o   (rsp_err),
    .busy_o      (busy),
    .alu_op_a_o  (alu_op_a),
    .alu_op_b_o  (alu_op_b),
    .alu_opcode_o(alu_opcode),
    .alu_cin_o   (alu_cin),
    .alu_out_q_i (alu_out_q),
    .alu_cout_i  (alu_cout)
  );

  // Byte ALU: shifts act on A (left) and B (right); CMP yields 1=EQ, 2=GT, 3=LT.
  always_comb begin
    alu_out_q = 8'h00;
    alu_cout  = 1'b0;
    case (alu_opcode)
      4'd0: {alu_cout, alu_out_q} = {1'b0, alu_op_a} + {1'b0, alu_op_b} + {8'h00, alu_cin};
      4'd1: {alu_cout, alu_out_q} = {1'b0, alu_op_a} + {1'b0, ~alu_op_b} + {8'h00, alu_cin};
      4'd2: alu_out_q = {alu_op_a[6:0], alu_cin};
      4'd3: alu_out_q = {alu_cin, alu_op_b[7:1]};
      4'd4: alu_out_q = alu_op_a ^ alu_op_b;
      4'd5: alu_out_q = (alu_op_a == alu_op_b) ? 8'h01 : (alu_op_a > alu_op_b) ? 8'h02 : 8'h03;
      4'd6: alu_out_q = alu_op_a & alu_op_b;
      4'd7: alu_out_q = ~(alu_op_a & alu_op_b);
      4'd8: alu_out_q = alu_op_a | alu_op_b;
      4'd9: alu_out_q = ~(alu_op_a | alu_op_b);
      default: alu_out_q = 8'h00;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic ref_model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic cin, output logic [15:0] q, output logic co,
                           output logic er);
    logic [16:0] s;
    q  = 16'h0000;
    co = 1'b0;
    er = 1'b0;
    case (op)
      4'd0: begin s = {1'b0, a} + {1'b0, b} + {16'h0000, cin}; {co, q} = s; end
      4'd1: begin s = {1'b0, a} + {1'b0, ~b} + 17'd1; {co, q} = s; end
      4'd2: begin q = {a[14:0], cin}; co = a[15]; end
      4'd3: begin q = {cin, b[15:1]}; co = b[0]; end
      4'd4: q = a ^ b;
      4'd5: q = (a == b) ? 16'd1 : (a > b) ? 16'd2 : 16'd3;
      4'd6: q = a & b;
      4'd7: q = ~(a & b);
      4'd8: q = a | b;
      4'd9: q = ~(a | b);
      default: er = 1'b1;
    endcase
  endtask

  task automatic run_cmd(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input int hold);
    logic [15:0] eq;
    logic        ec;
    logic        ee;
    int          n;
    logic        got;
    ref_model(op, a, b, cin, eq, ec, ee);
    @(negedge clk);
    check_eq("ready_idle", {31'd0, cmd_ready}, 32'd1);
    cmd_opcode = op;
    cmd_a      = a;
    cmd_b      = b;
    cmd_cin    = cin;
    cmd_valid  = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    n   = 0;
    got = 1'b0;
    while (!got && n < 10) begin
      @(negedge clk);
      n++;
      if (rsp_valid) begin
        got = 1'b1;
      end else if (op > 4'd9) begin
        check_eq("bad_op_alu_idle", {19'd0, alu_op_a, alu_op_b, alu_opcode, alu_cin}, 32'd0);
      end
    end
    check_eq("latency", n, NB + 1);
    if (got) begin
      check_eq("rsp_q", {16'd0, rsp_q}, {16'd0, eq});
      check_eq("rsp_cout", {31'd0, rsp_cout}, {31'd0, ec});
      check_eq("rsp_err", {31'd0, rsp_err}, {31'd0, ee});
      check_eq("done_alu_zero", {19'd0, alu_op_a, alu_op_b, alu_opcode, alu_cin}, 32'd0);
      check_eq("done_not_ready", {31'd0, cmd_ready}, 32'd0);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check_eq("hold_valid", {31'd0, rsp_valid}, 32'd1);
        check_eq("hold_q", {16'd0, rsp_q}, {16'd0, eq});
        check_eq("hold_not_ready", {31'd0, cmd_ready}, 32'd0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check_eq("after_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check_eq("after_rsp_ready", {31'd0, cmd_ready}, 32'd1);
    end
  endtask

  initial begin
    logic [3:0]  rop;
    logic [15:0] ra;
    logic [15:0] rb;
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_opcode = 4'd0;
    cmd_a      = 16'd0;
    cmd_b      = 16'd0;
    cmd_cin    = 1'b0;
    rsp_ready  = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("rst_q", {16'd0, rsp_q}, 32'd0);
    check_eq("rst_cout_err", {30'd0, rsp_cout, rsp_err}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_alu", {19'd0, alu_op_a, alu_op_b, alu_opcode, alu_cin}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_ready", {31'd0, cmd_ready}, 32'd1);

    run_cmd(4'd0, 16'h00FF, 16'h0001, 1'b0, 0);
    run_cmd(4'd0, 16'hFFFF, 16'h0001, 1'b0, 0);
    run_cmd(4'd1, 16'h0100, 16'h0001, 1'b0, 1);
    run_cmd(4'd1, 16'h0000, 16'h0001, 1'b1, 0);
    run_cmd(4'd2, 16'h8081, 16'h0000, 1'b1, 0);
    run_cmd(4'd3, 16'h0000, 16'h0180, 1'b1, 0);
    run_cmd(4'd5, 16'h1200, 16'h11FF, 1'b0, 0);
    run_cmd(4'd5, 16'h1234, 16'h1234, 1'b0, 3);
    run_cmd(4'd5, 16'h10FF, 16'h1100, 1'b0, 0);
    run_cmd(4'hA, 16'h1234, 16'h5678, 1'b1, 0);

    // Reset mid-RUN drops the command without a response.
    @(negedge clk);
    cmd_opcode = 4'd0;
    cmd_a      = 16'h1111;
    cmd_b      = 16'h2222;
    cmd_valid  = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check_eq("midrun_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrun_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("midrun_rst_ready", {31'd0, cmd_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("midrun_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end

    for (int i = 0; i < 60; i++) begin
      rop = 4'($urandom_range(0, 11));
      ra  = 16'($urandom);
      rb  = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom);
      if ($urandom_range(0, 3) == 0) rb[15:8] = ra[15:8];
      run_cmd(rop, ra, rb, 1'($urandom), $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
